des_key_scheduler: RTL and testbench
====================================

# des_key_scheduler

- Sequences the DES key schedule for the round datapath.
- Accepts a 64-bit key through a valid/ready handshake and applies PC-1 into a 56-bit C/D register.
- Emits the 16 round subkeys (PC-2 applied), one per accepted output beat, with backpressure.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1); sits between the key input port and the Feistel round controller.

## Interface

Parameters: none (DES widths and shift schedule are fixed).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key offered
- key_ready  out  1  scheduler can accept a key
- key  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored
- decrypt  in  1  sampled with key: 0 = K1..K16, 1 = K16..K1
- abort  in  1  synchronous cancel of the current schedule
- sk_valid  out  1  subkey presented
- sk_ready  in  1  consumer accepts subkey
- subkey  out  [1:48]  PC-2 of current C/D register
- sk_round  out  [3:0]  output beat index 0..15, not key number
- sk_last  out  1  high with beat 15
- busy  out  1  high in GEN

## Operation

- States:
  - IDLE: key_ready=1, sk_valid=0.
  - GEN: key_ready=0, sk_valid=1.
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- C/D is a 56-bit register: C = bits 1..28, D = bits 29..56. Rotations act on each 28-bit half independently.
- **Key accept** (IDLE, key_valid & key_ready): latch mode, then load C/D:
  - encrypt: PC1(key) rotated left by S[1];
  - decrypt: PC1(key) unrotated (C16D16 = C0D0);
  - sk_round <= 0; go to GEN.
- **Beat transfer** in GEN (sk_valid & sk_ready):
  - sk_round = 15: go to IDLE and clear C/D to 0.
  - otherwise, with r = sk_round+1 (new beat index):
    - encrypt: C/D rotate left by S[r+1];
    - decrypt: C/D rotate right by S[17-r];
    - sk_round <= r.
- GEN without sk_ready: hold all state; subkey stable.
- subkey and sk_last are fixed wiring/decode of registers only (PC-2 of C/D; sk_round==15). No input-to-output combinational path.
- **abort** in GEN: go to IDLE next cycle and clear C/D. If sk_ready is also high that cycle, the beat counts as transferred to the consumer. Abort in IDLE: ignored; key acceptance unaffected.
- key and decrypt are ignored outside the accept cycle.
- Reset mid-schedule discards everything; no beat resumes.

## Timing

- Reset values: key_ready=1 after rst_n deasserts (held 0 while rst_n low); sk_valid=0; busy=0; sk_round=0; sk_last=0; C/D=0, so subkey=0.
- Accept at edge N: sk_valid=1 with beat 0 from cycle N+1.
- With sk_ready held high: beats 0..15 on cycles N+1..N+16. key_ready=1 again at N+17, giving a 17-cycle key-to-key period.
- key_ready is a pure function of state, so there is no back-to-back accept during GEN.
- Backpressure: each low cycle of sk_ready stalls exactly one cycle. Beat order and values are unchanged.

## Test plan

- Reset: assert rst_n low mid-GEN, then release.
  - Required: sk_valid=0, busy=0, subkey=0, key_ready=1 on the first cycle after release.
- Encrypt, key=133457799BBCDFF1, sk_ready=1:
  - C/D after PC-1 = F0CCAAF556678F;
  - beat0 = 1B02EFFC7072, beat1 = 79AED9DBC9E5, beat15 = CB3D8B0E17F5 with sk_last=1;
  - 16 consecutive beats, key_ready at N+17.
- Decrypt, same key:
  - beat0 = CB3D8B0E17F5, beat14 = 79AED9DBC9E5, beat15 = 1B02EFFC7072;
  - full sequence is the exact reverse of the encrypt sequence.
- Random sk_ready backpressure (≈50%):
  - subkey holds while sk_ready=0;
  - sequence identical to the stall-free run;
  - exactly 16 transfers.
- abort asserted at beat 5 with sk_ready=1:
  - beat 5 counts; IDLE next cycle;
  - subkey=0, key_ready=1;
  - a new key is then scheduled correctly from beat 0.
- key_valid held high during GEN with changing key/decrypt:
  - no effect until IDLE;
  - the next key is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/des_key_scheduler.sv
// DES key scheduler: takes a 64-bit key, applies PC-1, and streams the 16
// round subkeys (PC-2 of the rotating C/D register) in either encrypt
// order (K1..K16) or decrypt order (K16..K1), one per accepted beat.
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [1:64] key,
    input  logic        decrypt,
    input  logic        abort,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [1:48] subkey,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        busy
);

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state;
    logic [1:56] cd;
    logic        decrypt_mode;
    logic [1:56] key_pc1;
    logic [4:0]  enc_idx;
    logic [4:0]  dec_idx;
    logic        enc_two;
    logic        dec_two;
    logic        parity_unused;

    // Shift amount is 2 for every round except rounds 1, 2, 9 and 16.
    function automatic logic shift_is_two(input logic [4:0] round_num);
        case (round_num)
            5'd1, 5'd2, 5'd9, 5'd16: return 1'b0;
            default:                 return 1'b1;
        endcase
    endfunction

    // Left rotation of C and D halves independently (bit 1 is the MSB).
    function automatic logic [1:56] rot_left(input logic [1:56] v, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = v[1:28];
        d = v[29:56];
        if (two) begin
            c = {c[3:28], c[1:2]};
            d = {d[3:28], d[1:2]};
        end else begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
        end
        return {c, d};
    endfunction

    // Right rotation of C and D halves independently; undoes rot_left.
    function automatic logic [1:56] rot_right(input logic [1:56] v, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = v[1:28];
        d = v[29:56];
        if (two) begin
            c = {c[27:28], c[1:26]};
            d = {d[27:28], d[1:26]};
        end else begin
            c = {c[28], c[1:27]};
            d = {d[28], d[1:27]};
        end
        return {c, d};
    endfunction

    // PC-1: drop parity bits and permute into C (first 28) and D (last 28).
    assign key_pc1 = {
        key[57], key[49], key[41], key[33], key[25], key[17], key[9],
        key[1],  key[58], key[50], key[42], key[34], key[26], key[18],
        key[10], key[2],  key[59], key[51], key[43], key[35], key[27],
        key[19], key[11], key[3],  key[60], key[52], key[44], key[36],
        key[63], key[55], key[47], key[39], key[31], key[23], key[15],
        key[7],  key[62], key[54], key[46], key[38], key[30], key[22],
        key[14], key[6],  key[61], key[53], key[45], key[37], key[29],
        key[21], key[13], key[5],  key[28], key[20], key[12], key[4]
    };

    // Parity bits carry no key material.
    assign parity_unused = ^{key[8], key[16], key[24], key[32],
                             key[40], key[48], key[56], key[64]};

    // PC-2 is pure wiring of the C/D register, so subkey never sees inputs.
    assign subkey = {
        cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
        cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
        cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
        cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
        cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
        cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
        cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
        cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]
    };

    assign sk_last = (sk_round == 4'd15);

    // Next beat r = sk_round+1: encrypt uses S[r+1], decrypt uses S[17-r].
    assign enc_idx = {1'b0, sk_round} + 5'd2;
    assign dec_idx = 5'd16 - {1'b0, sk_round};
    assign enc_two = shift_is_two(enc_idx);
    assign dec_two = shift_is_two(dec_idx);

    // Schedule FSM: load C/D on key accept, step it on each transferred beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cd           <= '0;
            decrypt_mode <= 1'b0;
            sk_round     <= 4'd0;
            key_ready    <= 1'b0;
            sk_valid     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    key_ready <= 1'b1;
                    if (key_valid && key_ready) begin
                        decrypt_mode <= decrypt;
                        cd           <= decrypt ? key_pc1 : rot_left(key_pc1, 1'b0);
                        sk_round     <= 4'd0;
                        state        <= GEN;
                        key_ready    <= 1'b0;
                        sk_valid     <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                GEN: begin
                    if (abort || (sk_ready && sk_last)) begin
                        state     <= IDLE;
                        cd        <= '0;
                        sk_round  <= 4'd0;
                        key_ready <= 1'b1;
                        sk_valid  <= 1'b0;
                        busy      <= 1'b0;
                    end else if (sk_ready) begin
                        sk_round <= sk_round + 4'd1;
                        cd       <= decrypt_mode ? rot_right(cd, dec_two)
                                                 : rot_left(cd, enc_two);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: a behavioural DES key-schedule
// model produces the expected subkey sequence for random keys and modes.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        abort = 1'b0;
    logic        sk_valid;
    logic        sk_ready = 1'b0;
    logic [47:0] subkey;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [47:0] exp_seq [16];
    logic [47:0] got_seq [16];
    logic [55:0] cd_at_load;

    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
        63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_key_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .decrypt   (decrypt),
        .abort     (abort),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .subkey    (subkey),
        .sk_round  (sk_round),
        .sk_last   (sk_last),
        .busy      (busy)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [55:0] modelPc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            idx = 6'(64 - PC1_T[i]);
            r = {r[54:0], k[idx]};
        end
        return r;
    endfunction

    function automatic logic [47:0] modelPc2(input logic [55:0] v);
        logic [47:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            idx = 6'(56 - PC2_T[i]);
            r = {r[46:0], v[idx]};
        end
        return r;
    endfunction

    function automatic logic [27:0] modelRot(input logic [27:0] h, input int s);
        return (h << s) | (h >> (28 - s));
    endfunction

    // Textbook schedule: cumulative left shifts give K1..K16; decrypt reverses.
    task automatic computeExpected(input logic [63:0] k, input logic dec);
        logic [55:0] p;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] ks [16];
        p = modelPc1(k);
        c = p[55:28];
        d = p[27:0];
        for (int i = 0; i < 16; i++) begin
            c = modelRot(c, SHIFTS[i]);
            d = modelRot(d, SHIFTS[i]);
            ks[i] = modelPc2({c, d});
        end
        for (int i = 0; i < 16; i++)
            exp_seq[i] = dec ? ks[15 - i] : ks[i];
    endtask

    // Offer one key and stream its subkeys with the given sk_ready density.
    task automatic applyStimulus(input logic [63:0] k, input logic dec,
                                 input int ready_pct, input int abort_beat,
                                 input bit scramble, input logic [63:0] next_k,
                                 input logic next_dec, output int beats);
        int          waitc;
        int          cyc;
        int          stalls;
        bit          xfer;
        bit          aborted;
        logic [55:0] p;
        computeExpected(k, dec);
        p = modelPc1(k);
        key = k;
        decrypt = dec;
        key_valid = 1'b1;
        waitc = 0;
        while (key_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        checkOutput("accept_wait", waitc, 0);
        @(posedge clk); #1;
        if (!scramble) key_valid = 1'b0;
        cd_at_load = dut.cd;
        checkOutput("cd_load", dut.cd,
                    dec ? p : {modelRot(p[55:28], 1), modelRot(p[27:0], 1)});
        beats = 0;
        cyc = 0;
        stalls = 0;
        aborted = 1'b0;
        while (beats < 16 && cyc < 400 && !aborted) begin
            checkOutput("sk_valid", sk_valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("key_ready_gen", key_ready, 0);
            checkOutput($sformatf("subkey_b%0d", beats), subkey, exp_seq[beats]);
            checkOutput("sk_round", sk_round, beats);
            checkOutput("sk_last", sk_last, beats == 15);
            sk_ready = ($urandom_range(99) < ready_pct);
            if (beats == abort_beat) begin
                sk_ready = 1'b1;
                abort = 1'b1;
                aborted = 1'b1;
            end
            if (scramble) begin
                key = {$urandom, $urandom};
                decrypt = 1'($urandom_range(1));
                if (beats == 15 && sk_ready) begin
                    key = next_k;
                    decrypt = next_dec;
                end
            end
            xfer = sk_ready;
            if (xfer) got_seq[beats] = subkey;
            else stalls++;
            @(posedge clk); #1;
            cyc++;
            abort = 1'b0;
            sk_ready = 1'b0;
            if (xfer) beats++;
        end
        if (cyc >= 400) checkOutput("beat_timeout", cyc, 0);
        if (!aborted) checkOutput("cycles_to_idle", cyc, 16 + stalls);
        checkOutput("idle_sk_valid", sk_valid, 0);
        checkOutput("idle_key_ready", key_ready, 1);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_subkey", subkey, 0);
    endtask

    initial begin
        int          beats;
        logic [63:0] ka;
        logic [63:0] kb;
        logic        da;
        logic        db;

        // Power-on reset.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_key_ready", key_ready, 0);
        checkOutput("rst_sk_valid", sk_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_key_ready", key_ready, 1);
        checkOutput("post_rst_sk_valid", sk_valid, 0);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_subkey", subkey, 0);
        checkOutput("post_rst_sk_round", sk_round, 0);
        checkOutput("post_rst_sk_last", sk_last, 0);

        // Known-answer encrypt run.
        applyStimulus(64'h133457799BBCDFF1, 1'b0, 100, -1, 1'b0, '0, 1'b0, beats);
        checkOutput("enc_beats", beats, 16);
        checkOutput("enc_beat0", got_seq[0], 48'h1B02EFFC7072);
        checkOutput("enc_beat1", got_seq[1], 48'h79AED9DBC9E5);
        checkOutput("enc_beat15", got_seq[15], 48'hCB3D8B0E17F5);

        // Known-answer decrypt run.
        applyStimulus(64'h133457799BBCDFF1, 1'b1, 100, -1, 1'b0, '0, 1'b0, beats);
        checkOutput("dec_cd_pc1", cd_at_load, 56'hF0CCAAF556678F);
        checkOutput("dec_beat0", got_seq[0], 48'hCB3D8B0E17F5);
        checkOutput("dec_beat14", got_seq[14], 48'h79AED9DBC9E5);
        checkOutput("dec_beat15", got_seq[15], 48'h1B02EFFC7072);

        // Random keys and modes under roughly 50% backpressure.
        for (int i = 0; i < 6; i++) begin
            ka = {$urandom, $urandom};
            da = 1'($urandom_range(1));
            applyStimulus(ka, da, 50, -1, 1'b0, '0, 1'b0, beats);
            checkOutput("bp_beats", beats, 16);
        end

        // Abort at beat 5: that beat still transfers, then a fresh key.
        ka = {$urandom, $urandom};
        applyStimulus(ka, 1'b0, 100, 5, 1'b0, '0, 1'b0, beats);
        checkOutput("abort_beats", beats, 6);
        kb = {$urandom, $urandom};
        applyStimulus(kb, 1'b1, 100, -1, 1'b0, '0, 1'b0, beats);
        checkOutput("after_abort_beats", beats, 16);

        // key_valid held with churning key/decrypt during GEN.
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        da = 1'($urandom_range(1));
        db = ~da;
        applyStimulus(ka, da, 100, -1, 1'b1, kb, db, beats);
        checkOutput("held_beats", beats, 16);
        applyStimulus(kb, db, 100, -1, 1'b0, '0, 1'b0, beats);
        checkOutput("held_next_beats", beats, 16);

        // Reset in the middle of a schedule.
        key = {$urandom, $urandom};
        decrypt = 1'b0;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        sk_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_key_ready", key_ready, 0);
        checkOutput("mid_rst_sk_valid", sk_valid, 0);
        checkOutput("mid_rst_subkey", subkey, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sk_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_post_key_ready", key_ready, 1);
        checkOutput("mid_post_sk_valid", sk_valid, 0);
        checkOutput("mid_post_busy", busy, 0);
        checkOutput("mid_post_subkey", subkey, 0);
        checkOutput("mid_post_sk_round", sk_round, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
